// File: rtl/cpu_pkg.sv
// Shared definitions for the EX-stage integer divide unit.
// Holds op encodings, the sequencer state encoding and the default datapath width.
// No logic; only types, constants and small decode helpers.
package cpu_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIVW  = 2'b00,
    DIV_OP_MODW  = 2'b01,
    DIV_OP_DIVWU = 2'b10,
    DIV_OP_MODWU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  // Bit 1 of the op selects unsigned, bit 0 selects remainder.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[1];
  endfunction

  function automatic logic op_is_mod(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/div_core_u32.sv
// Unsigned radix-2 restoring divide datapath: one quotient bit per step.
// Latency: WIDTH steps after load; uq/ur show the values the current step produces.
// No backpressure; the sequencer decides when to load and step.
import cpu_pkg::*;

module div_core_u32 #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] uq,
  output logic [WIDTH-1:0] ur
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             take;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  // A clear top bit of diff means no borrow, so the divisor fits.
  // The step result is exposed combinationally so the sequencer can register
  // the final answer on the same edge as the last step.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    diff  = trial - {1'b0, dvs_q};
    take  = ~diff[WIDTH];
    ur    = take ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    uq    = {quo_q[WIDTH-2:0], take};
  end

  // Load the operands, then commit one iteration per step.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= a;
      dvs_q <= b;
    end else if (step) begin
      rem_q <= ur;
      quo_q <= uq;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Divide sequencer for div.w/mod.w/div.wu/mod.wu: sign handling, handshakes, flush.
// Latency: res_valid rises exactly WIDTH edges after the accepting edge.
// Holds the result while res_ready is low; accepts only in IDLE; cancel aborts.
import cpu_pkg::*;

module div_ctrl #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cancel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e       state;
  div_state_e       state_nxt;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic             neg_q;
  logic             neg_r;
  logic             div0_q;
  logic [WIDTH-1:0] a_raw_q;

  logic             accept;
  logic             step;
  logic             last_step;
  logic             req_signed;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;
  logic [WIDTH-1:0] fixed_res;

  // Handshake qualifiers and operand magnitudes; cancel always wins.
  always_comb begin
    accept     = (state == IDLE) && req_valid && !cancel;
    step       = (state == CALC) && !cancel;
    last_step  = step && (cnt == LAST);
    req_signed = op_is_signed(req_op);
    abs_a      = (req_signed && src1[WIDTH-1]) ? -src1 : src1;
    abs_b      = (req_signed && src2[WIDTH-1]) ? -src2 : src2;
  end

  div_core_u32 #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .resetn (resetn),
    .load   (accept),
    .step   (step),
    .a      (abs_a),
    .b      (abs_b),
    .uq     (uq),
    .ur     (ur)
  );

  // Sign-correct the final step's output; divide-by-zero bypasses correction.
  always_comb begin
    fixed_res = '0;
    if (div0_q) begin
      fixed_res = op_is_mod(op_q) ? a_raw_q : '1;
    end else if (op_is_mod(op_q)) begin
      fixed_res = neg_r ? -ur : ur;
    end else begin
      fixed_res = neg_q ? -uq : uq;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cancel) state_nxt = IDLE;
               else if (last_step) state_nxt = DONE;
      DONE:    if (cancel || res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    res_valid = (state == DONE);
  end

  // Operand side-info captured at accept, iteration count, and the result hold register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      op_q    <= DIV_OP_DIVW;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div0_q  <= 1'b0;
      a_raw_q <= '0;
      result  <= '0;
    end else begin
      if (accept) begin
        cnt     <= '0;
        op_q    <= req_op;
        neg_q   <= req_signed && (src1[WIDTH-1] ^ src2[WIDTH-1]);
        neg_r   <= req_signed && src1[WIDTH-1];
        div0_q  <= (src2 == '0);
        a_raw_q <= src1;
      end else if (step) begin
        cnt <= cnt + CW'(1);
      end
      if (last_step) result <= fixed_res;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with hand-computed expected values.
// Inputs change and outputs are sampled 1ns after each rising edge.
// Each comparison is an immediate assertion feeding the pass/fail counters.
import cpu_pkg::*;

module tb_div_ctrl;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        cancel;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] result;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int edges;

  div_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .src1      (src1),
    .src2      (src2),
    .cancel    (cancel),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle, then scramble operands to prove they were latched.
  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    src1      = a;
    src2      = b;
    tick();
    req_valid = 1'b0;
    src1      = 32'hDEAD_BEEF;
    src2      = 32'h0000_0003;
    check("busy_after_accept", {31'b0, busy}, 32'd1);
  endtask

  // Count edges until res_valid, bounded so a dead DUT cannot hang the run.
  task automatic wait_result(output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n;
    start(op, a, b);
    wait_result(n);
    check({tag, "_latency"}, 32'(n), 32'd32);
    check(tag, result, exp);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_delivered"}, {31'b0, res_valid}, 32'd0);
  endtask

  initial begin
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_op    = DIV_OP_DIVW;
    src1      = '0;
    src2      = '0;
    cancel    = 1'b0;
    res_ready = 1'b0;
    #2;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_busy",      {31'b0, busy},      32'd0);
    check("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("rst_result",    result,             32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Basic signed/unsigned quotients and remainders.
    run_op("divw_7_2",        DIV_OP_DIVW,  32'd7,         32'd2,         32'd3);
    run_op("modw_m7_2",       DIV_OP_MODW,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_op("divw_m7_2",       DIV_OP_DIVW,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_op("divwu_max_16",    DIV_OP_DIVWU, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF);
    run_op("modwu_max_16",    DIV_OP_MODWU, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F);
    run_op("divw_100_m7",     DIV_OP_DIVW,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2);
    run_op("modw_m100_7",     DIV_OP_MODW,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE);
    // Overflow and divide by zero.
    run_op("divw_ovf",        DIV_OP_DIVW,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("modw_ovf",        DIV_OP_MODW,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("divwu_div0",      DIV_OP_DIVWU, 32'd5,         32'd0,         32'hFFFF_FFFF);
    run_op("modw_div0",       DIV_OP_MODW,  32'h8000_0005, 32'd0,         32'h8000_0005);
    run_op("divw_div0_neg",   DIV_OP_DIVW,  32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFFF);

    // Result held under backpressure, then a request waiting during delivery.
    start(DIV_OP_DIVWU, 32'd100, 32'd7);
    wait_result(edges);
    check("hold_latency", 32'(edges), 32'd32);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid",  {31'b0, res_valid}, 32'd1);
      check("hold_result", result,             32'd14);
    end
    res_ready = 1'b1;
    req_valid = 1'b1;
    req_op    = DIV_OP_DIVWU;
    src1      = 32'd1000;
    src2      = 32'd10;
    tick();
    res_ready = 1'b0;
    check("deliver_valid_low",   {31'b0, res_valid}, 32'd0);
    check("deliver_no_accept",   {31'b0, busy},      32'd0);
    check("deliver_ready_again", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check("next_accept_busy",  {31'b0, busy},      32'd1);
    check("next_accept_ready", {31'b0, req_ready}, 32'd0);
    wait_result(edges);
    check("next_latency", 32'(edges), 32'd32);
    check("next_result",  result,     32'd100);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Cancel mid-calculation: nothing delivered, then a clean follow-up.
    start(DIV_OP_DIVW, 32'd1000, 32'd3);
    repeat (10) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_busy",  {31'b0, busy},      32'd0);
    check("cancel_ready", {31'b0, req_ready}, 32'd1);
    wait_result(edges);
    check("cancel_no_result", {31'b0, res_valid}, 32'd0);
    run_op("after_cancel_divwu_100_7", DIV_OP_DIVWU, 32'd100, 32'd7, 32'd14);

    // Cancel together with res_ready in DONE.
    start(DIV_OP_DIVWU, 32'd9, 32'd3);
    wait_result(edges);
    check("cdone_result", result, 32'd3);
    cancel    = 1'b1;
    res_ready = 1'b1;
    tick();
    cancel    = 1'b0;
    res_ready = 1'b0;
    check("cdone_valid", {31'b0, res_valid}, 32'd0);
    check("cdone_ready", {31'b0, req_ready}, 32'd1);

    // Reset asserted mid-calculation takes effect without a clock edge.
    start(DIV_OP_DIVW, 32'd50, 32'd5);
    repeat (5) tick();
    resetn = 1'b0;
    #1;
    check("mid_rst_valid",  {31'b0, res_valid}, 32'd0);
    check("mid_rst_ready",  {31'b0, req_ready}, 32'd1);
    check("mid_rst_busy",   {31'b0, busy},      32'd0);
    check("mid_rst_result", result,             32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Cancel beats a simultaneous request in IDLE.
    req_valid = 1'b1;
    cancel    = 1'b1;
    req_op    = DIV_OP_DIVW;
    src1      = 32'd8;
    src2      = 32'd2;
    tick();
    req_valid = 1'b0;
    cancel    = 1'b0;
    check("cancel_blocks_accept", {31'b0, busy},      32'd0);
    check("cancel_blocks_ready",  {31'b0, req_ready}, 32'd1);
    run_op("post_reset_divw_8_2", DIV_OP_DIVW, 32'd8, 32'd2, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
